// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MTHI  = 2'b10,
      OP_MTLO  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mode_e;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/response bundle between the EX stage and the HI/LO sequencer.
interface mult_div_sequencer_if #(
   parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             read_hilo;
   logic             busy;
   logic             done;
   logic             stall_req;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, A, B, read_hilo,
      input  busy, done, stall_req, div_zero, hi, lo
   );

   modport slave (
      input  start, op, A, B, read_hilo,
      output busy, done, stall_req, div_zero, hi, lo
   );
endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// MUL: acc + (lsb ? operand : 0); acc_o is the sum shifted right, bit_o drops
//      into the top of the low half of the product.
// DIV: {acc, lsb} trial-subtracts operand; bit_o is the quotient bit.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic             lsb_i,
   input  logic [WIDTH-1:0] operand_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             bit_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic             no_borrow;
   logic [WIDTH-1:0] diff;

   // Both datapaths are evaluated; mode picks which one feeds the registers.
   always_comb begin
      sum       = {1'b0, acc_i} + (lsb_i ? {1'b0, operand_i} : '0);
      shifted   = {acc_i, lsb_i};
      no_borrow = shifted[WIDTH] | (shifted[WIDTH-1:0] >= operand_i);
      // When no borrow occurs the true difference is below operand, so the
      // low WIDTH bits of the modulo subtraction are exact.
      diff      = shifted[WIDTH-1:0] - operand_i;
      acc_o     = sum[WIDTH:1];
      bit_o     = sum[0];
      if (mode_i == MODE_DIV) begin
         bit_o = no_borrow;
         acc_o = no_borrow ? diff : shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer plus MTHI/MTLO; owns HI/LO and stalls the
// pipeline while a result is pending.
module mult_div_sequencer
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   mult_div_sequencer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;
   // acc holds product-high / remainder, low holds multiplier / dividend
   // shifting out while product-low / quotient shifts in.
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] low_q, low_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;

   op_e              op_w;
   mode_e            step_mode;
   logic             step_lsb;
   logic [WIDTH-1:0] step_acc;
   logic             step_bit;
   logic [WIDTH-1:0] low_next;

   assign op_w      = op_e'(bus.op);
   assign step_mode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;
   assign step_lsb  = (state_q == ST_DIV) ? low_q[WIDTH-1] : low_q[0];
   assign low_next  = (state_q == ST_DIV) ? {low_q[WIDTH-2:0], step_bit}
                                          : {step_bit, low_q[WIDTH-1:1]};

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .lsb_i     (step_lsb),
      .operand_i (opnd_q),
      .mode_i    (step_mode),
      .acc_o     (step_acc),
      .bit_o     (step_bit)
   );

   // State, counter, HI/LO and working registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
         acc_q   <= '0;
         low_q   <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
         acc_q   <= acc_d;
         low_q   <= low_d;
         opnd_q  <= opnd_d;
      end
   end

   // Next-state: accept requests in IDLE, iterate in MUL/DIV, one DONE cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      acc_d   = acc_q;
      low_d   = low_q;
      opnd_d  = opnd_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               dz_d = 1'b0;
               unique case (op_w)
                  OP_MTHI: hi_d = bus.A;
                  OP_MTLO: lo_d = bus.A;
                  OP_MULTU: begin
                     acc_d   = '0;
                     low_d   = bus.B;
                     opnd_d  = bus.A;
                     count_d = CNT_W'(WIDTH);
                     state_d = ST_MUL;
                  end
                  OP_DIVU: begin
                     if (bus.B == '0) begin
                        hi_d    = bus.A;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                     end else begin
                        acc_d   = '0;
                        low_d   = bus.A;
                        opnd_d  = bus.B;
                        count_d = CNT_W'(WIDTH);
                        state_d = ST_DIV;
                     end
                  end
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            acc_d   = step_acc;
            low_d   = low_next;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               hi_d    = step_acc;
               lo_d    = low_next;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.stall_req = bus.busy & (bus.read_hilo | bus.start);
   assign bus.div_zero  = dz_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for the HI/LO multiply/divide sequencer.
module tb_mult_div_sequencer;
   import mdu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;
   int   nbusy;
   bit   seen;

   mult_div_sequencer_if #(.WIDTH(32)) bus ();

   mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Returns at the negedge inside the done cycle (or after a bounded wait).
   task automatic wait_done(output int nb, output bit sd);
      nb = 0;
      sd = 1'b0;
      for (int i = 0; i < 40 && !sd; i++) begin
         @(negedge clk);
         if (bus.done) sd = 1'b1;
         else if (bus.busy) nb++;
      end
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.A = '0;
      bus.B = '0;
      bus.read_hilo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_dz", 64'(bus.div_zero), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MULTU 7*6, then a start during DONE must be ignored
      issue(OP_MULTU, 32'd7, 32'd6);
      wait_done(nbusy, seen);
      check("mul1_seen", 64'(seen), 64'd1);
      check("mul1_busycyc", 64'(nbusy), 64'd32);
      check("mul1_hi", 64'(bus.hi), 64'd0);
      check("mul1_lo", 64'(bus.lo), 64'd42);
      bus.start = 1'b1;
      bus.op = OP_MTHI;
      bus.A = 32'd77;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("done_start_ign", 64'(bus.hi), 64'd0);
      @(negedge clk);
      check("mul1_done1cyc", 64'(bus.done), 64'd0);
      check("mul1_idle", 64'(bus.busy), 64'd0);

      // MULTU max*max
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nbusy, seen);
      check("mul2_seen", 64'(seen), 64'd1);
      check("mul2_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

      // DIVU 100/7 with read_hilo held: stall until done; hi/lo frozen while busy
      bus.read_hilo = 1'b1;
      issue(OP_DIVU, 32'd100, 32'd7);
      @(negedge clk);
      check("div_stall", 64'(bus.stall_req), 64'd1);
      check("div_hold_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      wait_done(nbusy, seen);
      check("div_seen", 64'(seen), 64'd1);
      check("div_busycyc", 64'(nbusy), 64'd31);
      check("div_stall_done", 64'(bus.stall_req), 64'd0);
      check("div_lo", 64'(bus.lo), 64'd14);
      check("div_hi", 64'(bus.hi), 64'd2);
      check("div_dz", 64'(bus.div_zero), 64'd0);
      bus.read_hilo = 1'b0;

      // DIVU by zero: one-cycle result
      issue(OP_DIVU, 32'd5, 32'd0);
      @(negedge clk);
      check("dz_done", 64'(bus.done), 64'd1);
      check("dz_busy", 64'(bus.busy), 64'd0);
      check("dz_hi", 64'(bus.hi), 64'd5);
      check("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
      check("dz_flag", 64'(bus.div_zero), 64'd1);
      @(negedge clk);

      // Following MULTU clears div_zero; a start while busy is ignored
      issue(OP_MULTU, 32'd2, 32'd3);
      check("dz_clear", 64'(bus.div_zero), 64'd0);
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      bus.op = OP_MTLO;
      bus.A = 32'hDEAD;
      #1;
      check("busy_stall_start", 64'(bus.stall_req), 64'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(nbusy, seen);
      check("mul3_seen", 64'(seen), 64'd1);
      check("mul3_lo", 64'(bus.lo), 64'd6);
      check("mul3_hi", 64'(bus.hi), 64'd0);
      @(negedge clk);

      // MTHI / MTLO: immediate, never busy or done
      issue(OP_MTHI, 32'h1234, 32'd0);
      check("mthi_hi", 64'(bus.hi), 64'h1234);
      check("mthi_busy", 64'(bus.busy), 64'd0);
      check("mthi_done", 64'(bus.done), 64'd0);
      issue(OP_MTLO, 32'hABCD, 32'd0);
      check("mtlo_lo", 64'(bus.lo), 64'hABCD);
      check("mtlo_hi", 64'(bus.hi), 64'h1234);
      @(negedge clk);
      check("mtlo_done", 64'(bus.done), 64'd0);
      check("mtlo_busy", 64'(bus.busy), 64'd0);

      // Reset mid-MULTU abandons the operation
      issue(OP_MULTU, 32'd9, 32'd9);
      repeat (10) @(negedge clk);
      check("pre_rst_busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 64'(bus.busy), 64'd0);
      check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      check("mrst_no_done", 64'(seen), 64'd0);
      check("mrst_hilo_after", {bus.hi, bus.lo}, 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
